icache_ctrl: RTL and testbench

Direct-mapped instruction-cache controller sitting between the IFU and the cache storage: it drives the 128-entry tag array and the 128-bit line data array, compares tags, returns hits in one cycle, and refills misses from memory with a two-beat 64-bit burst. It also performs a full invalidate (fence.i) by walking all 128 tag entries.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_line_buf.sv | 35 +++
 rtl/icache_ctrl.sv | 122 ++++++++++++
 tb/tb_icache_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, tag-entry layout, FSM states and word-select helper for icache_ctrl
package icache_pkg;
    localparam int IDX_W     = 7;
    localparam int OFF_W     = 4;
    localparam int TAG_W     = 64 - IDX_W - OFF_W;
    localparam int LINE_W    = 128;
    localparam int ENTRY_W   = TAG_W + 2;
    localparam int VALID_BIT = 54;
    localparam int DIRTY_BIT = 53;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, FILL, FLUSH} state_t;

    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line, input logic [1:0] w);
        return line[w*32 +: 32];
    endfunction
endpackage

// File: rtl/icache_line_buf.sv
// icache_line_buf: assembles two 64-bit memory beats into one 128-bit cache line
//   clk, rst_n    : clock, synchronous active-low reset
//   clear         : restart at beat 0 (held while the line request is outstanding)
//   beat_valid    : a beat is presented on beat_data this cycle
//   beat_data     : 64-bit beat, beat 0 = low half of the line
//   line          : assembled line
//   done          : the current beat completes the line
module icache_line_buf
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [63:0]       beat_data,
    output logic [LINE_W-1:0] line,
    output logic              done
);
    logic cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= 1'b0;
            line <= '0;
        end else if (clear) begin
            cnt <= 1'b0;
        end else if (beat_valid) begin
            if (cnt) line[127:64] <= beat_data;
            else     line[63:0]   <= beat_data;
            cnt <= ~cnt;
        end
    end

    assign done = beat_valid && cnt;
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped I-cache controller (lookup, two-beat refill, fence.i walk)
//   clk, rst_n              : clock, synchronous active-low reset
//   req_*                   : IFU fetch request (valid/ready/addr)
//   resp_valid, resp_data   : one-cycle instruction response
//   flush, flush_busy       : invalidate-all request and walk status
//   tag_*                   : 128-entry tag array port {valid, dirty, tag}
//   data_*                  : 128-entry line data array port
//   mem_req_*, mem_resp_*   : line read request and 64-bit read beats
module icache_ctrl
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [63:0]        req_addr,
    output logic               resp_valid,
    output logic [31:0]        resp_data,
    input  logic               flush,
    output logic               flush_busy,
    output logic [IDX_W-1:0]   tag_addr,
    output logic               tag_en,
    output logic [ENTRY_W-1:0] tag_wdata,
    input  logic [ENTRY_W-1:0] tag_rdata,
    output logic [IDX_W-1:0]   data_addr,
    output logic               data_en,
    output logic [LINE_W-1:0]  data_wdata,
    input  logic [LINE_W-1:0]  data_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [63:0]        mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [63:0]        mem_resp_data
);
    state_t             state, state_nxt;
    logic [63:2]        addr_q;
    logic [IDX_W-1:0]   flush_cnt;
    logic               flush_pend;
    logic [LINE_W-1:0]  line;
    logic               line_done;
    logic               hit;
    logic               unused_bits;

    wire [TAG_W-1:0] tag  = addr_q[63:11];
    wire [IDX_W-1:0] idx  = addr_q[10:4];
    wire [1:0]       word = addr_q[3:2];

    icache_line_buf u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == MISS_REQ),
        .beat_valid(state == REFILL && mem_resp_valid),
        .beat_data (mem_resp_data),
        .line      (line),
        .done      (line_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            flush_cnt  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
            // IDLE always either starts the walk or has nothing pending, so it clears the flag
            flush_pend <= (state == IDLE) ? 1'b0 : (flush_pend || flush);
            if (req_valid && req_ready) addr_q <= req_addr[63:2];
        end
    end

    assign hit           = tag_rdata[VALID_BIT] && tag_rdata[TAG_W-1:0] == tag;
    assign data_addr     = idx;
    assign data_wdata    = line;
    assign mem_req_addr  = {addr_q[63:OFF_W], {OFF_W{1'b0}}};
    assign flush_busy    = flush_pend || state == FLUSH;
    assign unused_bits   = ^{req_addr[1:0], tag_rdata[DIRTY_BIT]};

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        tag_addr      = idx;
        tag_en        = 1'b0;
        tag_wdata     = '0;
        data_en       = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !(flush || flush_pend);
                if (flush || flush_pend) state_nxt = FLUSH;
                else if (req_valid)      state_nxt = LOOKUP;
            end
            LOOKUP: begin
                resp_valid = hit;
                resp_data  = hit ? pick_word(data_rdata, word) : '0;
                state_nxt  = hit ? IDLE : MISS_REQ;
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = REFILL;
            end
            REFILL: if (line_done) state_nxt = FILL;
            FILL: begin
                tag_en     = 1'b1;
                data_en    = 1'b1;
                tag_wdata  = {1'b1, 1'b0, tag};
                resp_valid = 1'b1;
                resp_data  = pick_word(line, word);
                state_nxt  = IDLE;
            end
            FLUSH: begin
                tag_en   = 1'b1;
                tag_addr = flush_cnt;
                if (flush_cnt == IDX_W'(127)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed self-checking bench with behavioural tag/data arrays
module tb_icache_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_addr = '0;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         flush = 1'b0;
    logic         flush_busy;
    logic [6:0]   tag_addr;
    logic         tag_en;
    logic [54:0]  tag_wdata;
    logic [54:0]  tag_rdata;
    logic [6:0]   data_addr;
    logic         data_en;
    logic [127:0] data_wdata;
    logic [127:0] data_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [63:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [63:0]  mem_resp_data = '0;

    logic [54:0]  tag_mem  [128];
    logic [127:0] data_mem [128];

    int n_cmp = 0;
    int n_err = 0;

    icache_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .flush         (flush),
        .flush_busy    (flush_busy),
        .tag_addr      (tag_addr),
        .tag_en        (tag_en),
        .tag_wdata     (tag_wdata),
        .tag_rdata     (tag_rdata),
        .data_addr     (data_addr),
        .data_en       (data_en),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    assign tag_rdata  = tag_mem[tag_addr];
    assign data_rdata = data_mem[data_addr];

    always @(posedge clk) begin
        if (tag_en)  tag_mem[tag_addr]   <= tag_wdata;
        if (data_en) data_mem[data_addr] <= data_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic fetch_miss(input logic [63:0] a, input logic [63:0] b0, input logic [63:0] b1,
                              input logic [31:0] want, input int wait_n);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        chk("miss_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
        #1;
        chk("miss_lookup", {resp_valid, mem_req_valid}, 0);
        tick;
        #1;
        for (int i = 0; i < wait_n; i++) begin
            chk("mreq_hold", {mem_req_valid, mem_req_addr}, {1'b1, a & ~64'hf});
            tick;
            #1;
        end
        chk("mreq", {mem_req_valid, mem_req_addr}, {1'b1, a & ~64'hf});
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = b0;
        tick;
        mem_resp_data = b1;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("fill_resp", {resp_valid, resp_data}, {1'b1, want});
        chk("fill_tag", {tag_en, data_en, tag_wdata}, {2'b11, 1'b1, 1'b0, a[63:11]});
        tick;
        chk("fill_line", data_mem[a[10:4]], {b1, b0});
    endtask

    task automatic fetch_hit(input logic [63:0] a, input logic [31:0] want);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        chk("hit_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
        #1;
        chk("hit_resp", {resp_valid, resp_data, mem_req_valid, req_ready}, {1'b1, want, 2'b00});
        tick;
    endtask

    task automatic flush_walk;
        for (int i = 0; i < 128; i++) begin
            #1;
            chk("flush_walk", {tag_en, data_en, flush_busy, tag_addr, tag_wdata}, {3'b101, 7'(i), 55'd0});
            tick;
        end
        #1;
        chk("flush_done", {flush_busy, tag_en, req_ready}, 3'b001);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
        tick;
        tick;
        #1;
        chk("reset", {req_ready, resp_valid, resp_data, flush_busy, tag_en, data_en, mem_req_valid, mem_req_addr},
            {1'b1, 1'b0, 32'd0, 4'd0, 64'd0});
        rst_n = 1'b1;
        tick;

        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        #1;
        chk("flush_vs_req", req_ready, 0);
        tick;
        flush     = 1'b0;
        req_valid = 1'b0;
        flush_walk;

        fetch_miss(64'h8000_0000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 32'h3333_4444, 0);
        chk("cold_tag_entry", tag_mem[0], 55'h40_0000_0010_0000);
        fetch_hit(64'h8000_000C, 32'h5555_6666);
        fetch_hit(64'h8000_0004, 32'h1111_2222);

        fetch_miss(64'h8000_0800, 64'hAAAA_BBBB_CCCC_DDDD, 64'hEEEE_FFFF_0000_1111, 32'hCCCC_DDDD, 5);
        fetch_miss(64'h8000_0000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 32'h3333_4444, 0);

        req_valid = 1'b1;
        req_addr  = 64'h8000_0040;
        tick;
        req_valid = 1'b0;
        tick;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0BAD_F00D_1234_5678;
        flush          = 1'b1;
        tick;
        flush         = 1'b0;
        mem_resp_data = 64'h9999_8888_7777_6666;
        #1;
        chk("busy_refill", {flush_busy, req_ready}, 2'b10);
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("fill_with_flush", {resp_valid, resp_data, tag_en, flush_busy}, {1'b1, 32'h1234_5678, 2'b11});
        tick;
        #1;
        chk("pending_idle", {req_ready, flush_busy, tag_en}, 3'b010);
        tick;
        flush_walk;
        chk("flushed_entries", {tag_mem[0], tag_mem[4]}, 110'd0);
        fetch_miss(64'h8000_0000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 32'h3333_4444, 0);

        req_valid = 1'b1;
        req_addr  = 64'h8000_0800;
        tick;
        req_valid = 1'b0;
        tick;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_0000_0001;
        tick;
        mem_resp_valid = 1'b0;
        rst_n          = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;
        chk("reset_abort", {mem_req_valid, req_ready, resp_valid, tag_en}, 4'b0100);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_0000_0002;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("stray_beat", {req_ready, tag_en, data_en, resp_valid}, 4'b1000);
        fetch_miss(64'h8000_0808, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 32'h7654_3210, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
